// File: rtl/sb_pkg.sv
`timescale 1ns/1ps
// Shared constants, state encodings and defaults for the sideband receive path.
package sb_pkg;

  localparam logic [7:0] DLE = 8'hFE;
  localparam logic [7:0] STX = 8'h05;
  localparam logic [7:0] ETX = 8'h40;

  localparam int MAX_AT_BYTES_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    GOT_DLE,
    LT_CLSE,
    LT_DLE,
    LT_ETX,
    AT_DATA,
    AT_DLE
  } dfr_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

endpackage

// File: rtl/sb_uart_rx.sv
`timescale 1ns/1ps
// One-sample-per-bit byte receiver for the sideband line (start, 8 data LSB first, stop).
module sb_uart_rx
  import sb_pkg::*;
(
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err
);

  rx_state_t  state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] data_next;
  logic       pend_valid_reg, pend_valid_next;
  logic       pend_ferr_reg, pend_ferr_next;

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    data_next       = byte_data;
    pend_valid_next = 1'b0;
    pend_ferr_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        if (!sbrx) begin
          state_next   = RX_DATA;
          bit_cnt_next = 3'd0;
        end
      end
      RX_DATA: begin
        shift_next   = {sbrx, shift_reg[7:1]};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) state_next = RX_STOP;
      end
      RX_STOP: begin
        if (sbrx) begin
          pend_valid_next = 1'b1;
          data_next       = shift_reg;
          state_next      = RX_IDLE;
        end else begin
          // A low stop bit may be a break; do not rearm until the line idles.
          pend_ferr_next = 1'b1;
          state_next     = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (sbrx) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_reg      <= RX_IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      byte_data      <= 8'h00;
      pend_valid_reg <= 1'b0;
      pend_ferr_reg  <= 1'b0;
      byte_valid     <= 1'b0;
      framing_err    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      byte_data      <= data_next;
      pend_valid_reg <= pend_valid_next;
      pend_ferr_reg  <= pend_ferr_next;
      byte_valid     <= pend_valid_reg;
      framing_err    <= pend_ferr_reg;
    end
  end

endmodule

// File: rtl/sb_rx_deframer.sv
`timescale 1ns/1ps
// Sideband receive deframer: splits the byte stream into LT symbol transactions and
// DLE-stuffed AT payload frames, emitted through a one-byte holding register.
module sb_rx_deframer
  import sb_pkg::*;
#(
  parameter int MAX_AT_BYTES = MAX_AT_BYTES_DEF
) (
  input  logic       sb_clk,
  input  logic       rst,
  input  logic       sbrx,
  output logic       lt_valid,
  output logic [7:0] lt_lse,
  output logic       lt_err,
  output logic [7:0] at_data,
  output logic       at_valid,
  output logic       at_sop,
  output logic       at_eop,
  output logic       at_err
);

  localparam int               CNT_W     = $clog2(MAX_AT_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_AT_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       framing_err;

  sb_uart_rx u_rx (
    .sb_clk     (sb_clk),
    .rst        (rst),
    .sbrx       (sbrx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .framing_err(framing_err)
  );

  dfr_state_t       state_reg, state_next;
  logic [7:0]       cand_reg, cand_next;
  logic [7:0]       hold_reg, hold_next;
  logic             hold_valid_reg, hold_valid_next;
  logic             first_reg, first_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             payload;
  logic [7:0]       pay_byte;
  logic             lt_valid_next, lt_err_next, at_valid_next;
  logic             at_sop_next, at_eop_next, at_err_next;
  logic [7:0]       lt_lse_next, at_data_next;

  always_comb begin
    state_next      = state_reg;
    cand_next       = cand_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    first_next      = first_reg;
    cnt_next        = cnt_reg;
    cnt_inc         = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
    payload         = 1'b0;
    pay_byte        = byte_data;
    lt_valid_next   = 1'b0;
    lt_lse_next     = lt_lse;
    lt_err_next     = 1'b0;
    at_data_next    = at_data;
    at_valid_next   = 1'b0;
    at_sop_next     = 1'b0;
    at_eop_next     = 1'b0;
    at_err_next     = 1'b0;

    if (framing_err) begin
      if (state_reg == AT_DATA || state_reg == AT_DLE) at_err_next = 1'b1;
      else if (state_reg != IDLE)                      lt_err_next = 1'b1;
      state_next = IDLE;
    end else if (byte_valid) begin
      case (state_reg)
        IDLE: if (byte_data == DLE) state_next = GOT_DLE;
        GOT_DLE: begin
          if (byte_data == STX) begin
            state_next      = AT_DATA;
            hold_valid_next = 1'b0;
            first_next      = 1'b1;
            cnt_next        = '0;
          end else if (byte_data == ETX) begin
            state_next = IDLE;
          end else if (byte_data != DLE) begin
            cand_next  = byte_data;
            state_next = LT_CLSE;
          end
        end
        LT_CLSE: begin
          state_next = (byte_data == ~cand_reg) ? LT_DLE : IDLE;
          lt_err_next = (byte_data != ~cand_reg);
        end
        LT_DLE: begin
          state_next  = (byte_data == DLE) ? LT_ETX : IDLE;
          lt_err_next = (byte_data != DLE);
        end
        LT_ETX: begin
          state_next = IDLE;
          if (byte_data == ETX) begin
            lt_valid_next = 1'b1;
            lt_lse_next   = cand_reg;
          end else begin
            lt_err_next = 1'b1;
          end
        end
        AT_DATA: begin
          if (byte_data == DLE) state_next = AT_DLE;
          else                  payload    = 1'b1;
        end
        AT_DLE: begin
          if (byte_data == DLE) begin
            payload    = 1'b1;
            pay_byte   = DLE;
            state_next = AT_DATA;
          end else if (byte_data == ETX) begin
            state_next = IDLE;
            if (hold_valid_reg) begin
              at_valid_next = 1'b1;
              at_data_next  = hold_reg;
              at_sop_next   = first_reg;
              at_eop_next   = 1'b1;
            end else begin
              at_err_next = 1'b1;
            end
          end else begin
            at_err_next = 1'b1;
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase

      // The held byte goes out only once a successor proves it is not the last one.
      if (payload) begin
        cnt_next = cnt_inc;
        if (cnt_inc > CNT_LIMIT) begin
          at_err_next = 1'b1;
          state_next  = IDLE;
        end else begin
          if (hold_valid_reg) begin
            at_valid_next = 1'b1;
            at_data_next  = hold_reg;
            at_sop_next   = first_reg;
            first_next    = 1'b0;
          end
          hold_next       = pay_byte;
          hold_valid_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cand_reg       <= 8'h00;
      hold_reg       <= 8'h00;
      hold_valid_reg <= 1'b0;
      first_reg      <= 1'b0;
      cnt_reg        <= '0;
      lt_valid       <= 1'b0;
      lt_lse         <= 8'h00;
      lt_err         <= 1'b0;
      at_data        <= 8'h00;
      at_valid       <= 1'b0;
      at_sop         <= 1'b0;
      at_eop         <= 1'b0;
      at_err         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cand_reg       <= cand_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      first_reg      <= first_next;
      cnt_reg        <= cnt_next;
      lt_valid       <= lt_valid_next;
      lt_lse         <= lt_lse_next;
      lt_err         <= lt_err_next;
      at_data        <= at_data_next;
      at_valid       <= at_valid_next;
      at_sop         <= at_sop_next;
      at_eop         <= at_eop_next;
      at_err         <= at_err_next;
    end
  end

endmodule

// File: tb/tb_sb_rx_deframer.sv
`timescale 1ns/1ps
// Bench for sb_rx_deframer: directed vector table, hand-written corner sequences,
// and random frame streams checked against a frame-level parsing model.
module tb_sb_rx_deframer;

  localparam int DLE_I = 254;
  localparam int STX_I = 5;
  localparam int ETX_I = 64;
  localparam int MAXB  = 16;

  logic       sb_clk = 1'b0;
  logic       rst    = 1'b1;
  logic       sbrx   = 1'b1;
  logic       lt_valid, lt_err, at_valid, at_sop, at_eop, at_err;
  logic [7:0] lt_lse, at_data;

  sb_rx_deframer #(.MAX_AT_BYTES(MAXB)) dut (
    .sb_clk  (sb_clk),
    .rst     (rst),
    .sbrx    (sbrx),
    .lt_valid(lt_valid),
    .lt_lse  (lt_lse),
    .lt_err  (lt_err),
    .at_data (at_data),
    .at_valid(at_valid),
    .at_sop  (at_sop),
    .at_eop  (at_eop),
    .at_err  (at_err)
  );

  always #500 sb_clk = ~sb_clk;

  // kind: 0 lt_valid, 1 lt_err, 2 at_valid, 3 at_err
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } ev_t;

  typedef struct {
    int           nb;
    logic [191:0] bytes;
    int           ferr;
    int           n_at, n_sop, n_eop;
    logic [7:0]   first, last;
    int           n_ltv;
    logic [7:0]   lse;
    int           n_lte, n_ate;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         excl_viol = 0;
  int         last_stop_cyc = 0;
  ev_t        got_q[$];
  int         got_cyc[$];
  ev_t        exp_q[$];
  int         tok_q[$];
  logic [7:0] mq[$];
  logic [7:0] model_lse;

  always @(posedge sb_clk) cyc <= cyc + 1;

  always @(negedge sb_clk) begin
    int  nh;
    ev_t e;
    if (!rst) begin
      nh = int'(lt_valid) + int'(lt_err) + int'(at_valid) + int'(at_err);
      if (nh > 1) excl_viol = excl_viol + 1;
      if (nh != 0) begin
        e.kind = lt_valid ? 2'd0 : lt_err ? 2'd1 : at_valid ? 2'd2 : 2'd3;
        e.data = lt_valid ? lt_lse : at_valid ? at_data : 8'h00;
        e.sop  = at_sop;
        e.eop  = at_eop;
        got_q.push_back(e);
        got_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #(64'd100_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string what, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", what, got, exp);
    end
  endtask

  task automatic send_tok(input int t, input int gap);
    logic [7:0] d;
    logic [9:0] bits;
    d    = (t < 0) ? 8'($urandom_range(0, 255)) : 8'(t);
    bits = {(t >= 0), d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge sb_clk);
      sbrx = bits[k];
    end
    @(posedge sb_clk);
    #1 last_stop_cyc = cyc;
    repeat (gap + ((t < 0) ? 1 : 0)) begin
      @(negedge sb_clk);
      sbrx = 1'b1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge sb_clk);
    rst  = 1'b1;
    sbrx = 1'b1;
    repeat (2) @(negedge sb_clk);
    check({tag, " reset outputs"},
          int'({lt_valid, lt_lse, lt_err, at_data, at_valid, at_sop, at_eop, at_err}), 0);
    rst = 1'b0;
    got_q.delete();
    got_cyc.delete();
  endtask

  function automatic void push_ev(input int kind, input int data, input bit sop, input bit eop);
    ev_t e;
    e.kind = 2'(kind);
    e.data = 8'(data);
    e.sop  = sop;
    e.eop  = eop;
    exp_q.push_back(e);
  endfunction

  // Payload collected in mq: a clean end emits all of it, otherwise the last byte is lost.
  function automatic void at_close(input bit finish, input bit err);
    int nemit;
    nemit = finish ? mq.size() : mq.size() - 1;
    for (int j = 0; j < nemit; j++)
      push_ev(2, int'(mq[j]), j == 0, finish && (j == nemit - 1));
    if (err) push_ev(3, 0, 1'b0, 1'b0);
  endfunction

  // Frame-level parse of the token stream (-1 marks a byte with a bad stop bit).
  function automatic void ref_model();
    int  i, n, t, u, k, lse;
    int  expv[3];
    bit  done, ok;
    exp_q.delete();
    model_lse = 8'h00;
    n = tok_q.size();
    i = 0;
    while (i < n) begin
      t = tok_q[i]; i++;
      if (t == DLE_I) begin
        while (i < n && tok_q[i] == DLE_I) i++;
        if (i < n) begin
          t = tok_q[i]; i++;
          if (t < 0) begin
            push_ev(1, 0, 1'b0, 1'b0);
          end else if (t == STX_I) begin
            mq.delete();
            done = 1'b0;
            while (!done) begin
              if (i >= n) begin
                at_close(1'b0, 1'b0);
                done = 1'b1;
              end else begin
                t = tok_q[i]; i++;
                if (t < 0) begin
                  at_close(1'b0, 1'b1);
                  done = 1'b1;
                end else if (t == DLE_I) begin
                  if (i >= n) begin
                    at_close(1'b0, 1'b0);
                    done = 1'b1;
                  end else begin
                    u = tok_q[i]; i++;
                    if (u == ETX_I) begin
                      if (mq.size() == 0) at_close(1'b0, 1'b1);
                      else                at_close(1'b1, 1'b0);
                      done = 1'b1;
                    end else if (u != DLE_I) begin
                      at_close(1'b0, 1'b1);
                      done = 1'b1;
                    end
                  end
                end
                if (!done) begin
                  if (mq.size() >= MAXB) begin
                    at_close(1'b0, 1'b1);
                    done = 1'b1;
                  end else begin
                    mq.push_back(8'(t));
                  end
                end
              end
            end
          end else if (t != ETX_I) begin
            lse = t;
            expv[0] = 255 - lse;
            expv[1] = DLE_I;
            expv[2] = ETX_I;
            ok = 1'b1;
            k = 0;
            while (ok && k < 3 && i < n) begin
              if (tok_q[i] != expv[k]) ok = 1'b0;
              i++;
              k++;
            end
            if (!ok) begin
              push_ev(1, 0, 1'b0, 1'b0);
            end else if (k == 3) begin
              push_ev(0, lse, 1'b0, 1'b0);
              model_lse = 8'(lse);
            end
          end
        end
      end
    end
  endfunction

  function automatic int pick_lse();
    int b;
    do b = $urandom_range(0, 255); while (b == DLE_I || b == STX_I || b == ETX_I);
    return b;
  endfunction

  task automatic gen_stream(input int nframes);
    int b, len, lse;
    tok_q.delete();
    for (int f = 0; f < nframes; f++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          lse = pick_lse();
          tok_q.push_back(DLE_I); tok_q.push_back(lse);
          tok_q.push_back(255 - lse); tok_q.push_back(DLE_I); tok_q.push_back(ETX_I);
        end
        2: begin
          tok_q.push_back(DLE_I); tok_q.push_back(pick_lse());
          for (int j = 0; j < 3; j++) tok_q.push_back($urandom_range(0, 255));
        end
        3, 4: begin
          len = $urandom_range(0, 18);
          tok_q.push_back(DLE_I); tok_q.push_back(STX_I);
          for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) begin
              tok_q.push_back(DLE_I); tok_q.push_back(DLE_I);
            end else begin
              b = $urandom_range(0, 255);
              tok_q.push_back((b == DLE_I) ? 8'h7E : b);
            end
          end
          tok_q.push_back(DLE_I);
          tok_q.push_back(($urandom_range(0, 4) != 0) ? ETX_I : 8'h33);
        end
        default: begin
          for (int j = 0; j < $urandom_range(1, 3); j++) tok_q.push_back($urandom_range(0, 255));
        end
      endcase
    end
    foreach (tok_q[j]) if ($urandom_range(0, 39) == 0) tok_q[j] = -1;
  endtask

  vec_t vt[10];

  function automatic vec_t mk(input int nb, input logic [191:0] bytes, input int ferr,
                              input int n_at, input int n_sop, input int n_eop,
                              input logic [7:0] first, input logic [7:0] last,
                              input int n_ltv, input logic [7:0] lse,
                              input int n_lte, input int n_ate);
    vec_t v;
    v.nb = nb; v.bytes = bytes; v.ferr = ferr;
    v.n_at = n_at; v.n_sop = n_sop; v.n_eop = n_eop;
    v.first = first; v.last = last;
    v.n_ltv = n_ltv; v.lse = lse; v.n_lte = n_lte; v.n_ate = n_ate;
    return v;
  endfunction

  initial begin
    int    n_at, n_sop, n_eop, n_ltv, n_lte, n_ate, nerr;
    int    first, last;
    string tag;

    vt[0] = mk(5, 40'hFE837CFE40, -1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h83, 0, 0);
    vt[1] = mk(5, 40'hFE837DFE40, -1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
    vt[2] = mk(8, 64'hFE0511FEFE22FE40, -1, 3, 1, 1, 8'h11, 8'h22, 0, 8'h00, 0, 0);
    vt[3] = mk(21, 168'hFE05_000102030405060708090A0B0C0D0E0F10_FE40, -1,
               15, 1, 0, 8'h00, 8'h0E, 0, 8'h00, 0, 1);
    vt[4] = mk(8, 64'hFE0511FE837CFE40, 2, 0, 0, 0, 8'h00, 8'h00, 1, 8'h83, 0, 1);
    vt[5] = mk(4, 32'hFE05FE40, -1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1);
    vt[6] = mk(5, 40'hFE05AAFE40, -1, 1, 1, 1, 8'hAA, 8'hAA, 0, 8'h00, 0, 0);
    vt[7] = mk(5, 40'h1234FEFE40, -1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    vt[8] = mk(2, 16'hFE00, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
    vt[9] = mk(4, 32'hFE837C11, -1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);

    repeat (3) @(negedge sb_clk);
    do_reset("initial");

    // Directed vector table
    for (int v = 0; v < 10; v++) begin
      do_reset($sformatf("vec%0d", v));
      for (int k = 0; k < vt[v].nb; k++)
        send_tok((k == vt[v].ferr) ? -1 : int'(vt[v].bytes[8*(vt[v].nb-1-k) +: 8]), 1);
      repeat (20) @(negedge sb_clk);
      n_at = 0; n_sop = 0; n_eop = 0; n_ltv = 0; n_lte = 0; n_ate = 0; first = 0; last = 0;
      foreach (got_q[j]) begin
        case (got_q[j].kind)
          2'd0: n_ltv++;
          2'd1: n_lte++;
          2'd2: begin
            if (n_at == 0) first = int'(got_q[j].data);
            last = int'(got_q[j].data);
            n_at++;
            if (got_q[j].sop) n_sop++;
            if (got_q[j].eop) n_eop++;
          end
          default: n_ate++;
        endcase
      end
      tag = $sformatf("vec%0d", v);
      check({tag, " at_bytes"}, n_at, vt[v].n_at);
      check({tag, " at_sop"}, n_sop, vt[v].n_sop);
      check({tag, " at_eop"}, n_eop, vt[v].n_eop);
      if (vt[v].n_at > 0) begin
        check({tag, " first_byte"}, first, int'(vt[v].first));
        check({tag, " last_byte"}, last, int'(vt[v].last));
      end
      check({tag, " lt_valid"}, n_ltv, vt[v].n_ltv);
      check({tag, " lt_lse"}, int'(lt_lse), int'(vt[v].lse));
      check({tag, " lt_err"}, n_lte, vt[v].n_lte);
      check({tag, " at_err"}, n_ate, vt[v].n_ate);
      $display("[TB] vec%0d: at=%0d ltv=%0d lte=%0d ate=%0d lse=%02h", v, n_at, n_ltv, n_lte, n_ate, lt_lse);
    end

    // LT latency: lt_valid exactly two cycles after the final stop-bit sample, lse held afterwards
    do_reset("latency");
    send_tok(DLE_I, 0); send_tok(8'h83, 0); send_tok(8'h7C, 0); send_tok(DLE_I, 0); send_tok(ETX_I, 0);
    repeat (10) @(negedge sb_clk);
    check("latency event_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("latency cycles", got_cyc[0] - last_stop_cyc, 2);
      check("latency kind", int'(got_q[0].kind), 0);
    end
    check("latency lse_held", int'(lt_lse), 8'h83);
    check("latency lt_valid_low", int'(lt_valid), 0);
    $display("[TB] latency: events=%0d lse=%02h", got_q.size(), lt_lse);

    // Reset in the middle of an AT payload byte
    do_reset("midframe");
    send_tok(DLE_I, 0); send_tok(STX_I, 0); send_tok(8'h11, 0); send_tok(8'h22, 0); send_tok(8'h33, 0);
    @(negedge sb_clk); sbrx = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge sb_clk); sbrx = k[0];
    end
    check("midframe pre_events", got_q.size(), 2);
    nerr = 0;
    foreach (got_q[j]) if (got_q[j].kind != 2'd2) nerr++;
    check("midframe pre_err", nerr, 0);
    do_reset("midframe");
    repeat (3) @(negedge sb_clk);
    check("midframe post_reset_events", got_q.size(), 0);
    send_tok(DLE_I, 1); send_tok(STX_I, 1); send_tok(8'hAA, 1); send_tok(DLE_I, 1); send_tok(ETX_I, 1);
    repeat (10) @(negedge sb_clk);
    check("midframe after events", got_q.size(), 1);
    if (got_q.size() > 0)
      check("midframe after event", int'(got_q[0]), int'({2'd2, 8'hAA, 1'b1, 1'b1}));
    $display("[TB] midframe: events after reset=%0d", got_q.size());

    // Random frame streams against the reference model
    for (int r = 0; r < 4; r++) begin
      do_reset($sformatf("rand%0d", r));
      gen_stream(20);
      ref_model();
      foreach (tok_q[j]) send_tok(tok_q[j], $urandom_range(0, 2));
      repeat (30) @(negedge sb_clk);
      tag = $sformatf("rand%0d", r);
      check({tag, " event_count"}, got_q.size(), exp_q.size());
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
        check($sformatf("%s event%0d {kind,data,sop,eop}", tag, j), int'(got_q[j]), int'(exp_q[j]));
      check({tag, " lt_lse"}, int'(lt_lse), int'(model_lse));
      $display("[TB] rand%0d: tokens=%0d events=%0d expected=%0d", r, tok_q.size(), got_q.size(), exp_q.size());
    end

    check("one_hot_strobes violations", excl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
